aqp_clkmon: RTL

- Single-clock frequency monitor for a synthesized clock, such as the video pixel clock.
- The monitored domain drives a toggle bit, which inverts on every monitored-clock rising edge. This block synchronizes that bit into `clk` and counts its transitions over a fixed gate window of `clk` cycles.
- Each window's count is published. A lock state machine flags when the monitored clock is stably inside the expected frequency range.
- Used for bring-up status and to hold off video logic until the pixel clock is good.

---
 rtl/aqp_clkmon.sv | 82 ++++++++
 1 files changed

// File: rtl/aqp_clkmon.sv
// aqp_clkmon: gated transition counter on a synchronized toggle, with range check and lock FSM.
module aqp_clkmon #(
  parameter int GATE_CYCLES = 28636,
  parameter int CNT_W       = 16,
  parameter int EXP_MIN     = 25100,
  parameter int EXP_MAX     = 25250,
  parameter int LOCK_COUNT  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             meas_tgl,
  output logic [CNT_W-1:0] freq_count,
  output logic             count_valid,
  output logic             in_range,
  output logic             locked,
  output logic             lock_lost
);
  localparam int GW = $clog2(GATE_CYCLES);
  localparam int SW = $clog2(LOCK_COUNT + 1);
  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;
  state_t           state;
  logic             sync_q1, sync_q2, prev, primed;
  logic [GW-1:0]    gate;
  logic [CNT_W-1:0] cnt, total;
  logic [SW-1:0]    streak;
  logic             tgl_edge, wend, hit;
  assign tgl_edge = sync_q2 ^ prev;
  assign wend     = gate == GW'(GATE_CYCLES - 1);
  // an edge landing on the window-end cycle still belongs to the closing window
  assign total    = (tgl_edge && cnt != '1) ? cnt + CNT_W'(1) : cnt;
  assign hit      = total >= CNT_W'(EXP_MIN) && total <= CNT_W'(EXP_MAX);
  assign locked   = state == LOCKED;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1     <= 1'b0;
      sync_q2     <= 1'b0;
      prev        <= 1'b0;
      primed      <= 1'b0;
      gate        <= '0;
      cnt         <= '0;
      streak      <= '0;
      state       <= UNLOCKED;
      freq_count  <= '0;
      count_valid <= 1'b0;
      in_range    <= 1'b0;
      lock_lost   <= 1'b0;
    end else begin
      sync_q1     <= meas_tgl;
      sync_q2     <= sync_q1;
      prev        <= sync_q2;
      gate        <= wend ? '0 : gate + GW'(1);
      cnt         <= wend ? '0 : total;
      count_valid <= wend && primed;
      lock_lost   <= 1'b0;
      if (wend) primed <= 1'b1;
      // the first window after reset may hold a spurious edge, so it is never published
      if (wend && primed) begin
        freq_count <= total;
        in_range   <= hit;
        case (state)
          UNLOCKED: if (hit) begin
            streak <= SW'(1);
            state  <= LOCK_COUNT == 1 ? LOCKED : ACQUIRE;
          end
          ACQUIRE: if (!hit) begin
            streak <= '0;
            state  <= UNLOCKED;
          end else begin
            streak <= streak + SW'(1);
            if (streak + SW'(1) == SW'(LOCK_COUNT)) state <= LOCKED;
          end
          LOCKED: if (!hit) begin
            streak    <= '0;
            state     <= UNLOCKED;
            lock_lost <= 1'b1;
          end
          default: state <= UNLOCKED;
        endcase
      end
    end
  end
endmodule
